// File: rtl/fp_pkg.sv
// Shared types and constants for the float/int32 converter and the fpu datapath.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    NORM,
    FIN
  } state_t;

  localparam logic [7:0]  BIAS        = 8'd127;
  localparam logic [7:0]  EXP_INT_MAX = 8'd158;
  localparam logic [7:0]  EXP_SPECIAL = 8'd255;
  localparam logic [31:0] INT_POS_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_NEG_SAT = 32'h8000_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic [23:0] sig;       // significand with hidden bit restored
    logic        is_zero;
    logic        is_denorm;
    logic        is_inf;
    logic        is_nan;
  } fp_fields_t;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational split of a binary32 word into fields and class flags.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0] a,
  output fp_fields_t  f
);

  logic exp_zero;
  logic exp_max;
  logic frac_zero;

  always_comb begin
    exp_zero    = (a[30:23] == 8'd0);
    exp_max     = (a[30:23] == EXP_SPECIAL);
    frac_zero   = (a[22:0] == 23'd0);
    f.sign      = a[31];
    f.exp       = a[30:23];
    f.frac      = a[22:0];
    f.sig       = {~exp_zero, a[22:0]};
    f.is_zero   = exp_zero & frac_zero;
    f.is_denorm = exp_zero & ~frac_zero;
    f.is_inf    = exp_max & frac_zero;
    f.is_nan    = exp_max & ~frac_zero;
  end

endmodule

// File: rtl/fp_cvt.sv
// Multi-cycle int32 <-> binary32 converter, truncating, one shift per cycle.
module fp_cvt
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] A,
  output logic        ready,
  output logic [31:0] C
);

  state_t      state_q, state_n;
  logic        op_q, op_n;
  logic [31:0] a_q, a_n;
  logic        sign_q, sign_n;
  logic [31:0] mag_q, mag_n;
  logic [7:0]  exp_q, exp_n;
  logic [4:0]  cnt_q, cnt_n;
  logic        spec_q, spec_n;
  logic [31:0] spec_val_q, spec_val_n;
  logic [31:0] c_q, c_n;

  fp_fields_t  uf;
  logic [7:0]  exp_gap;

  fp_unpack u_unpack (
    .a (a_q),
    .f (uf)
  );

  always_comb begin
    state_n    = state_q;
    op_n       = op_q;
    a_n        = a_q;
    sign_n     = sign_q;
    mag_n      = mag_q;
    exp_n      = exp_q;
    cnt_n      = cnt_q;
    spec_n     = spec_q;
    spec_val_n = spec_val_q;
    c_n        = c_q;
    exp_gap    = EXP_INT_MAX - uf.exp;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_n     = A;
          op_n    = op;
          state_n = LOAD;
        end
      end

      LOAD: begin
        state_n    = NORM;
        spec_n     = 1'b0;
        spec_val_n = '0;
        cnt_n      = '0;
        exp_n      = '0;
        mag_n      = '0;
        sign_n     = 1'b0;
        if (!op_q) begin
          sign_n = a_q[31];
          mag_n  = a_q[31] ? neg32(a_q) : a_q;
          exp_n  = EXP_INT_MAX;
          if (a_q == '0) begin
            spec_n = 1'b1;
          end
        end else begin
          sign_n = uf.sign;
          // Special and out-of-range results are fixed here; NORM then passes straight through.
          if (uf.is_nan) begin
            spec_n     = 1'b1;
            spec_val_n = INT_POS_SAT;
          end else if (uf.is_inf || uf.exp >= EXP_INT_MAX) begin
            spec_n     = 1'b1;
            spec_val_n = uf.sign ? INT_NEG_SAT : INT_POS_SAT;
          end else if (uf.exp < BIAS) begin
            spec_n     = 1'b1;
          end else begin
            mag_n = {uf.sig, 8'd0};
            cnt_n = exp_gap[4:0];
          end
        end
      end

      NORM: begin
        if (spec_q) begin
          state_n = FIN;
        end else if (!op_q) begin
          if (mag_q[31]) begin
            state_n = FIN;
          end else begin
            mag_n = {mag_q[30:0], 1'b0};
            exp_n = exp_q - 8'd1;
          end
        end else begin
          if (cnt_q == 5'd0) begin
            state_n = FIN;
          end else begin
            mag_n = {1'b0, mag_q[31:1]};
            cnt_n = cnt_q - 5'd1;
          end
        end
      end

      FIN: begin
        if (spec_q) begin
          c_n = spec_val_q;
        end else if (!op_q) begin
          c_n = {sign_q, exp_q, mag_q[30:8]};
        end else begin
          c_n = sign_q ? neg32(mag_q) : mag_q;
        end
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      a_q        <= '0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      exp_q      <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      c_q        <= '0;
    end else begin
      state_q    <= state_n;
      op_q       <= op_n;
      a_q        <= a_n;
      sign_q     <= sign_n;
      mag_q      <= mag_n;
      exp_q      <= exp_n;
      cnt_q      <= cnt_n;
      spec_q     <= spec_n;
      spec_val_q <= spec_val_n;
      c_q        <= c_n;
    end
  end

  assign ready = (state_q == IDLE);
  assign C     = c_q;

endmodule

// File: tb/tb_fp_cvt.sv
// Bench for fp_cvt: directed vectors, randomized model checks, control corner cases.
module tb_fp_cvt;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] A;
  logic        ready;
  logic [31:0] C;

  int passed = 0;
  int total  = 0;

  fp_cvt dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .ready (ready),
    .C     (C)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] c;
    int          lat;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Value-level reference: k is the number of single-bit shifts the conversion needs.
  function automatic void model(input logic o, input logic [31:0] a,
                                output logic [31:0] c, output int k);
    logic [63:0] m;
    logic [63:0] v;
    logic [7:0]  e;
    int          p;
    logic        s;
    c = 32'd0;
    k = 0;
    s = a[31];
    if (!o) begin
      if (a != 32'd0) begin
        m = s ? (64'd4294967296 - {32'd0, a}) : {32'd0, a};
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        k = 31 - p;
        v = (p >= 23) ? (m >> (p - 23)) : (m << (23 - p));
        e = 8'(127 + p);
        c = {s, e, v[22:0]};
      end
    end else begin
      e = a[30:23];
      if (e == 8'd255 && a[22:0] != 23'd0) c = 32'h7FFFFFFF;
      else if (e == 8'd255 || e >= 8'd158) c = s ? 32'h80000000 : 32'h7FFFFFFF;
      else if (e < 8'd127) c = 32'd0;
      else begin
        m = {40'd0, 1'b1, a[22:0]};
        v = (e >= 8'd150) ? (m << (e - 8'd150)) : (m >> (8'd150 - e));
        c = s ? (32'd0 - v[31:0]) : v[31:0];
        k = 158 - int'(e);
      end
    end
  endfunction

  task automatic wait_ready(output int lat);
    lat = 0;
    while (!ready && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input logic o, input logic [31:0] a,
                     output logic [31:0] c, output int lat);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = $urandom;
    op    = 1'($urandom);
    wait_ready(lat);
    c = C;
  endtask

  initial begin
    logic [31:0] c, exp_c, a;
    logic [7:0]  e;
    int          lat, k, r;

    tbl[0]  = '{1'b0, 32'h00000001, 32'h3F800000, 34};
    tbl[1]  = '{1'b0, 32'h00000000, 32'h00000000, 3};
    tbl[2]  = '{1'b0, 32'hFFFFFFFF, 32'hBF800000, 34};
    tbl[3]  = '{1'b0, 32'h80000000, 32'hCF000000, 3};
    tbl[4]  = '{1'b0, 32'h01000001, 32'h4B800000, 10};
    tbl[5]  = '{1'b1, 32'h40490FDB, 32'h00000003, 33};
    tbl[6]  = '{1'b1, 32'hC0400000, 32'hFFFFFFFD, 33};
    tbl[7]  = '{1'b1, 32'h3F7FFFFF, 32'h00000000, 3};
    tbl[8]  = '{1'b1, 32'h00000001, 32'h00000000, 3};
    tbl[9]  = '{1'b1, 32'h7F800000, 32'h7FFFFFFF, 3};
    tbl[10] = '{1'b1, 32'hFF800000, 32'h80000000, 3};
    tbl[11] = '{1'b1, 32'h7FC00000, 32'h7FFFFFFF, 3};
    tbl[12] = '{1'b1, 32'h4F000000, 32'h7FFFFFFF, 3};
    tbl[13] = '{1'b1, 32'hCF000000, 32'h80000000, 3};
    tbl[14] = '{1'b1, 32'h3F800000, 32'h00000001, 34};

    rst = 1'b1; start = 1'b0; op = 1'b0; A = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_c", C, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run(tbl[i].op, tbl[i].a, c, lat);
      check($sformatf("vec%0d_c", i), c, tbl[i].c);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
    end

    for (int i = 0; i < 150; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) a = 32'd0 - a;
      if ($urandom_range(0, 19) == 0) a = 32'd0;
      model(1'b0, a, exp_c, k);
      run(1'b0, a, c, lat);
      check($sformatf("rand_i2f_%h", a), c, exp_c);
      check($sformatf("rand_i2f_lat_%h", a), 32'(lat), 32'(3 + k));
    end

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) e = 8'd0;
      else if (r == 1) e = 8'd255;
      else e = 8'($urandom_range(110, 165));
      a = {1'($urandom), e, 23'($urandom)};
      model(1'b1, a, exp_c, k);
      run(1'b1, a, c, lat);
      check($sformatf("rand_f2i_%h", a), c, exp_c);
      check($sformatf("rand_f2i_lat_%h", a), 32'(lat), 32'(3 + k));
    end

    // start held high: one conversion, busy-time starts ignored, next accepted at once
    @(negedge clk);
    start = 1'b1; op = 1'b0; A = 32'h00000100;
    @(posedge clk);
    #1;
    check("held_busy", {31'd0, ready}, 32'd0);
    A = 32'h12345678;
    op = 1'b1;
    wait_ready(lat);
    check("held_first_c", C, 32'h43800000);
    check("held_first_lat", 32'(lat), 32'd26);
    A = 32'hFFFFFF00;
    op = 1'b0;
    @(posedge clk);
    #1;
    check("held_second_accept", {31'd0, ready}, 32'd0);
    start = 1'b0;
    wait_ready(lat);
    check("held_second_c", C, 32'hC3800000);
    check("held_second_lat", 32'(lat), 32'd26);

    // reset during NORM aborts, then a fresh conversion works
    @(negedge clk);
    start = 1'b1; op = 1'b0; A = 32'h00000001;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_c", C, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, 32'h01000001, c, lat);
    check("after_abort_c", c, 32'h4B800000);
    check("after_abort_lat", 32'(lat), 32'd10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fp_cvt.md
Name: fp_cvt

Overview:
Multi-cycle converter between IEEE-754 single precision and signed 32-bit integer.
- op=0 packs an int32 into a float (int→fp).
- op=1 unpacks a float into an int32 (fp→int).

It uses the same start/ready handshake and the same one-bit-per-cycle shift normalisation style as the team's fpu adder, and sits beside it in the calculator datapath. It feeds integer operands into fpu and returns fpu results to integer form.

Parameters:
None. Formats are fixed: IEEE-754 binary32 and two's-complement int32.

Ports:
clk    input   1   system clock; all state updates on the rising edge
rst    input   1   reset, synchronous, active-high
start  input   1   request; sampled only in IDLE
op     input   1   0 = int32→float, 1 = float→int32
A      input   32  operand; captured with op on the edge that accepts start
ready  output  1   1 = idle / result valid; 0 = busy
C      output  32  result register; holds its value until the next FIN

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset values: ready=1, C=0, state=IDLE, all internal registers 0.
- rst asserted mid-operation aborts. After that edge: ready=1, C=0, state=IDLE.
- States: IDLE, LOAD, NORM, FIN.
- IDLE:
  - ready=1.
  - If start=1 at edge E: latch A and op, ready<=0, go to LOAD.
  - start=0: stay in IDLE.
- Any start while busy is ignored and not queued.
- LOAD (edge E+1), op=0 (int→fp):
  - sign=A[31]; mag = sign ? -A : A (32-bit unsigned; 0x80000000 stays 2^31); exp=158.
  - A==0 sets a zero flag; result is 0x00000000.
- LOAD (edge E+1), op=1 (fp→int): e=A[30:23], m=A[22:0].
  - e==255 with m!=0 (NaN): result 0x7FFFFFFF.
  - e==255 with m==0, or e>=158: saturate to sign ? 0x80000000 : 0x7FFFFFFF.
  - e<127 (includes zero and denormals): result 0.
  - Otherwise mag={1,m,8'b0}, cnt=158-e (range 1..31).
- NORM, op=0:
  - If mag[31]==1 or the zero flag is set: go to FIN.
  - Else mag<<=1, exp-=1, stay.
- NORM, op=1:
  - Special/zero cases: go to FIN immediately.
  - If cnt==0: go to FIN.
  - Else mag>>=1, cnt-=1, stay.
- FIN:
  - op=0: C<={sign, exp, mag[30:8]}, or 0 if zero.
  - op=1: C<=sign ? -mag : mag, or the special value.
  - ready<=1, go to IDLE.
- Rounding is truncation toward zero in both directions, matching fpu. No -0 is ever produced from an integer.
- Latency: start sampled at edge E → C valid and ready=1 after edge E+3+k, where k = number of NORM shifts.
  - int→fp: k = leading-zero count of mag; k=0 for zero input.
  - fp→int: k=158-e; k=0 for special cases.
  - Maximum k is 31, so worst case is E+34.
- A new start may be accepted on the first cycle ready=1 after FIN (back-to-back).
- Inputs A and op may change freely after edge E.

Decomposition:
- Package fp_pkg holds:
  - state encodings (IDLE/LOAD/NORM/FIN);
  - BIAS=127, EXP_INT_MAX=158, EXP_SPECIAL=255;
  - INT_POS_SAT=32'h7FFFFFFF, INT_NEG_SAT=32'h80000000.
- One sub-module is natural: fp_unpack. It is combinational: sign/exp/mantissa split, hidden bit, denormal/zero/inf/NaN flags. fpu reuses it.

Test Plan:
- op=0, A=32'h00000001 → C=32'h3F800000; ready returns at E+34 (k=31). Also A=0 → C=0 at E+3.
- op=0, A=32'hFFFFFFFF → 32'hBF800000. A=32'h80000000 → 32'hCF000000 at E+3 (k=0).
- op=0, A=32'h01000001 (2^24+1) → 32'h4B800000 (truncated, k=7, E+10).
- op=1:
  - 32'h40490FDB → 32'h00000003 at E+33 (k=30);
  - 32'hC0400000 → 32'hFFFFFFFD;
  - 32'h3F7FFFFF → 0;
  - 32'h00000001 (denormal) → 0.
- op=1 saturation:
  - 32'h7F800000 → 32'h7FFFFFFF;
  - 32'hFF800000 → 32'h80000000;
  - 32'h7FC00000 → 32'h7FFFFFFF;
  - 32'h4F000000 → 32'h7FFFFFFF;
  - 32'hCF000000 → 32'h80000000.
- Control:
  - start held high for the whole operation → exactly one conversion, then a new one accepted immediately after ready rises.
  - rst=1 during NORM → after that edge ready=1, C=0; the next start converts correctly.
